// File: rtl/cover_pkg.sv
// Shared cover-point types: the global cover-point index is a 64-bit unsigned quantity.
package cover_pkg;
  localparam int COVER_INDEX_W = 64;
  typedef logic [COVER_INDEX_W-1:0] cover_idx_t;
endpackage

// File: rtl/cover_prio_enc.sv
// Combinational lowest-set-bit priority encoder over a WIDTH-bit request vector.
module cover_prio_enc #(
  parameter int WIDTH = 25,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan high-to-low so the last write wins with the lowest set bit.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: records first hits per point and streams each newly hit
// point's global index out through a valid/ready port, lowest pending bit first.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int         WIDTH       = 25,
  parameter cover_idx_t COVER_INDEX = '0,
  parameter int         COVER_TOTAL = 38253
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output cover_idx_t                   out_index,
  output logic [$clog2(WIDTH+1)-1:0]   hit_count,
  output logic                         all_hit
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W:0]   SUM_MAX = (CNT_W + 1)'(WIDTH);

  if (WIDTH < 1 || WIDTH > 4096) begin : g_bad_width
    $error("cover_toggle_collector: WIDTH must be in 1..4096");
  end
  if (COVER_TOTAL < WIDTH) begin : g_total_note
    $warning("cover_toggle_collector: COVER_TOTAL smaller than WIDTH");
  end

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > SUM_MAX) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  logic [WIDTH-1:0] hit_q, hit_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] new_hits, taken;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  cover_idx_t       out_index_q, out_index_d;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;
  logic             load;

  cover_prio_enc #(.WIDTH(WIDTH)) u_prio_enc (
    .req_i  (pending_q),
    .idx_o  (enc_idx),
    .found_o(enc_found)
  );

  always_comb begin
    new_hits    = valid & ~hit_q;
    load        = !out_valid_q || out_ready;
    taken       = '0;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    hit_d       = hit_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    if (clear) begin
      // A presented item may still complete its handshake, but nothing new is loaded.
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      hit_d     = '0;
      pending_d = '0;
      cnt_d     = '0;
    end else begin
      if (load) begin
        out_valid_d = enc_found;
        if (enc_found) begin
          out_index_d = COVER_INDEX + cover_idx_t'(enc_idx);
          taken       = WIDTH'(1) << enc_idx;
        end
      end
      hit_d     = hit_q | valid;
      pending_d = (pending_q | new_hits) & ~taken;
      cnt_d     = sat_add(cnt_q, popcount(new_hits));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_q       <= '0;
      pending_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
    end else begin
      hit_q       <= hit_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign hit_count = cnt_q;
  assign all_hit   = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Bench for cover_toggle_collector (WIDTH=25, COVER_INDEX=100): per-point model plus
// directed scenarios with hand-computed expectations.
module tb_cover_toggle_collector;

  localparam int          W  = 25;
  localparam logic [63:0] CI = 64'd100;

  logic          clock;
  logic          reset;
  logic [W-1:0]  valid;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_index;
  logic [4:0]    hit_count;
  logic          all_hit;

  cover_toggle_collector #(
    .WIDTH      (W),
    .COVER_INDEX(CI),
    .COVER_TOTAL(38253)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .valid    (valid),
    .clear    (clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .hit_count(hit_count),
    .all_hit  (all_hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;
  logic [63:0] acc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: per-point hit/pending flags and the presented output slot.
  bit          m_hit [W];
  bit          m_pend[W];
  bit          m_ov;
  logic [63:0] m_oi;

  function automatic int model_count();
    int n;
    n = 0;
    for (int i = 0; i < W; i++) n += m_hit[i] ? 1 : 0;
    return n;
  endfunction

  always @(posedge clock) begin : model
    int k;
    k = -1;
    if (!reset) begin
      for (int i = 0; i < W; i++) begin m_hit[i] = 1'b0; m_pend[i] = 1'b0; end
      m_ov = 1'b0;
      m_oi = 64'd0;
    end else if (clear) begin
      if (m_ov && out_ready) m_ov = 1'b0;
      for (int i = 0; i < W; i++) begin m_hit[i] = 1'b0; m_pend[i] = 1'b0; end
    end else begin
      if (!m_ov || out_ready) begin
        for (int i = 0; i < W; i++) if (m_pend[i] && k < 0) k = i;
        if (k >= 0) begin
          m_ov      = 1'b1;
          m_oi      = CI + 64'(k);
          m_pend[k] = 1'b0;
        end else begin
          m_ov = 1'b0;
        end
      end
      for (int i = 0; i < W; i++) begin
        if (valid[i] && !m_hit[i]) begin
          m_hit[i]  = 1'b1;
          m_pend[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cmp_out_valid", out_valid, m_ov);
      chk("cmp_out_index", out_index, m_oi);
      chk("cmp_hit_count", hit_count, 64'(model_count()));
      chk("cmp_all_hit",   all_hit,   model_count() == W);
    end
    if (reset && out_valid && out_ready) acc.push_back(out_index);
  end

  task automatic step(input logic [W-1:0] v, input logic clr, input logic rdy);
    valid     = v;
    clear     = clr;
    out_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; valid = '0; clear = 1'b0; out_ready = 1'b0;
    step('0, 1'b0, 1'b0);
    cmp_en = 1'b1;
    step('0, 1'b0, 1'b0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_all_hit",   all_hit,   0);
    reset = 1'b1;

    // Single strobe on bit 7
    step(W'(1) << 7, 1'b0, 1'b1);
    chk("s7_not_yet", out_valid, 0);
    chk("s7_count",   hit_count, 1);
    step('0, 1'b0, 1'b1);
    chk("s7_valid", out_valid, 1);
    chk("s7_index", out_index, 107);
    step('0, 1'b0, 1'b1);
    chk("s7_one_cycle", out_valid, 0);

    // Three bits in one cycle stream back-to-back
    step('0, 1'b1, 1'b1);
    chk("clr_count", hit_count, 0);
    step(25'h1000005, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    chk("s3_idx0", out_index, 100);
    step('0, 1'b0, 1'b1);
    chk("s3_idx1", out_index, 102);
    step('0, 1'b0, 1'b1);
    chk("s3_idx2", out_index, 124);
    chk("s3_v2",   out_valid, 1);
    step('0, 1'b0, 1'b1);
    chk("s3_done",  out_valid, 0);
    chk("s3_count", hit_count, 3);

    // Backpressure holds 103, then 104 follows
    step('0, 1'b1, 1'b1);
    step(25'h18, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step('0, 1'b0, 1'b0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_index", out_index, 103);
    end
    step('0, 1'b0, 1'b1);
    chk("bp_next_index", out_index, 104);
    step('0, 1'b0, 1'b1);
    chk("bp_drained", out_valid, 0);

    // Clear while an item is presented: it still completes, pending is dropped
    step('0, 1'b1, 1'b1);
    step(25'h18, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    acc.delete();
    step(W'(1) << 5, 1'b1, 1'b0);
    chk("mc_hold_valid", out_valid, 1);
    chk("mc_hold_index", out_index, 103);
    chk("mc_count",      hit_count, 0);
    step('0, 1'b0, 1'b1);
    chk("mc_no_reload", out_valid, 0);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    chk("mc_acc_size", acc.size(), 1);
    if (acc.size() >= 1) chk("mc_acc0", acc[0], 103);

    // Repeated strobes report once; after clear the point reports again
    step('0, 1'b1, 1'b1);
    acc.delete();
    for (int i = 0; i < 10; i++) step(W'(1) << 3, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    chk("rep_acc_size", acc.size(), 1);
    if (acc.size() >= 1) chk("rep_acc0", acc[0], 103);
    step('0, 1'b1, 1'b1);
    step(W'(1) << 3, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    chk("rep2_acc_size", acc.size(), 2);
    if (acc.size() >= 2) chk("rep2_acc1", acc[1], 103);
    chk("rep2_count", hit_count, 1);

    // All points at once
    step('0, 1'b1, 1'b1);
    acc.delete();
    step({W{1'b1}}, 1'b0, 1'b1);
    chk("all_count", hit_count, 25);
    chk("all_hit",   all_hit,   1);
    for (int i = 0; i < 26; i++) step('0, 1'b0, 1'b1);
    chk("all_acc_size", acc.size(), 25);
    for (int i = 0; i < 25 && i < acc.size(); i++) chk("all_acc_order", acc[i], 64'd100 + 64'(i));
    chk("all_drained", out_valid, 0);

    // Reset mid-handshake abandons the presented index
    step('0, 1'b1, 1'b1);
    acc.delete();
    step(W'(1) << 3, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    chk("rmh_presented", out_valid, 1);
    reset = 1'b0;
    step(W'(1) << 4, 1'b1, 1'b1);
    chk("rmh_valid", out_valid, 0);
    chk("rmh_index", out_index, 0);
    chk("rmh_count", hit_count, 0);
    chk("rmh_all",   all_hit,   0);
    reset = 1'b1;
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    chk("rmh_quiet",    out_valid, 0);
    chk("rmh_acc_size", acc.size(), 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cover_toggle_collector.md
COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 25: number of toggle cover points, legal range 1..4096.
REQ-002 SHALL have parameter COVER_INDEX, default 0: global index of cover point 0, 64-bit value.
REQ-003 SHALL have parameter COVER_TOTAL, default 38253: design-wide point count, informational only, never used in logic.
REQ-004 SHALL have port clock  input  1: rising-edge clock.
REQ-005 SHALL have port reset  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port valid  input  WIDTH: per-point toggle-hit strobes, sampled every cycle.
REQ-007 SHALL have port clear  input  1: synchronous clear of collected coverage state.
REQ-008 SHALL have port out_valid  output  1: a newly-hit point index is presented.
REQ-009 SHALL have port out_ready  input  1: consumer accepts out_index.
REQ-010 SHALL have port out_index  output  64: global index, COVER_INDEX + local bit number.
REQ-011 SHALL have port hit_count  output  clog2(WIDTH+1): number of distinct points hit since reset/clear.
REQ-012 SHALL have port all_hit  output  1: high when hit_count == WIDTH.

Function
REQ-013 SHALL keep a sticky hit bitmap; on each non-clear cycle, hit <= hit | valid.
REQ-014 SHALL keep a pending bitmap; on each non-clear cycle, pending <= (pending | (valid & ~hit)) & ~taken, where taken is the bit loaded into the output this cycle.
REQ-015 SHALL report each point at most once between resets/clears; repeat strobes on an already-hit point are ignored.
REQ-016 SHALL increment hit_count by popcount(valid & ~hit) each non-clear cycle, saturating at WIDTH.
REQ-017 SHALL load the output register when out_valid==0 or (out_valid && out_ready).
REQ-018 Load source SHALL be the lowest-numbered set bit of the registered pending bitmap; if none is set, out_valid <= 0.
REQ-019 SHALL hold out_valid and out_index stable while out_valid && !out_ready.
REQ-020 Latency SHALL be fixed: valid[k] sampled at edge N gives out_valid=1 with out_index=COVER_INDEX+k after edge N+1, provided the output is free and no lower pending bit exists.
REQ-021 Throughput SHALL be one index per cycle under continuous out_ready.
REQ-022 SHALL never drop a hit: the pending bitmap is the only buffer, and it cannot overflow.
REQ-023 clear SHALL zero hit, pending and hit_count at the next edge; valid in the clear cycle SHALL be ignored.
REQ-024 An out_valid item already presented SHALL complete its handshake despite clear; no new load SHALL occur in the clear cycle.
REQ-025 out_index arithmetic SHALL be 64-bit unsigned and SHALL wrap modulo 2^64.

Reset
REQ-026 When reset==0 at a rising edge, SHALL set hit=0, pending=0, hit_count=0, out_valid=0 and out_index=0.
REQ-027 all_hit SHALL be 0 after reset; this holds for any WIDTH>=1.
REQ-028 Reset SHALL override clear, valid and out_ready in the same cycle.
REQ-029 Reset mid-handshake SHALL abandon the presented index without reporting it.

Structure
REQ-030 The shared package cover_pkg SHALL hold the 64-bit cover-index type and the COVER_INDEX_W=64 constant.
REQ-031 SHALL instantiate one sub-module, cover_prio_enc (parameter WIDTH), which outputs the lowest set bit index and a found flag, purely combinationally.
REQ-032 SHALL contain no DPI calls and SHALL be synthesizable.

Verification (WIDTH=25, COVER_INDEX=100)
REQ-033 Scenario: reset low 2 cycles, then valid=0 -> out_valid=0, hit_count=0, all_hit=0.
REQ-034 Scenario: valid=1<<7 for one cycle, out_ready=1 -> out_valid high 2 edges later for exactly one cycle, out_index=107, hit_count=1.
REQ-035 Scenario: valid=0x1000005 in one cycle, out_ready=1 -> indices 100, 102, 124 on consecutive cycles, hit_count=3.
REQ-036 Scenario: out_ready=0 for 5 cycles with bits 3 and 4 pending -> out_index holds 103; after out_ready=1, 104 follows next cycle.
REQ-037 Scenario: bit 3 strobed 10 times -> exactly one report of 103; then clear, then strobe bit 3 again -> 103 reported again, hit_count=1.
REQ-038 Scenario: valid all-ones for one cycle -> 25 indices 100..124 in order, all_hit=1, hit_count=25.
